// File: rtl/barrel_pkg.sv
// Shared constants and types for the round-robin rotator arbiter.
// Modules take WIDTH/NREQ as parameters; these are the defaults they start from.
package barrel_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int SHW       = $clog2(DEF_WIDTH);
  localparam int IDW       = $clog2(DEF_NREQ);

  typedef enum logic {
    ROT_L = 1'b0,
    ROT_R = 1'b1
  } dir_e;

endpackage

// File: rtl/barrel_rot_arbiter_rr_grant.sv
// Round-robin priority encoder: first asserted request at or after ptr, wrapping.
module rr_grant #(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx
);

  always_comb begin
    logic found;
    int   idx;
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/barrel_shift_left.sv
// Combinational left rotator built as log2(WIDTH) conditional power-of-two stages.
module barrel_shift_left #(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] rot
);

  logic [WIDTH-1:0] stage [AMT_W+1];

  assign stage[0] = data;

  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    localparam int K = 1 << s;
    assign stage[s+1] = amt[s] ? {stage[s][WIDTH-1-K:0], stage[s][WIDTH-1 -: K]}
                               : stage[s];
  end

  assign rot = stage[AMT_W];

endmodule

// File: rtl/barrel_rot_arbiter.sv
// Shares one barrel rotator among NREQ requesters with round-robin arbitration
// and a single tagged output register (valid/ready on both sides).
module barrel_rot_arbiter
  import barrel_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  localparam int AMT_W = $clog2(WIDTH),
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*AMT_W-1:0] req_amt,
  input  logic [NREQ-1:0]       req_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [ID_W-1:0]       out_id
);

  logic [ID_W-1:0]  rr_ptr;
  logic             free;
  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [AMT_W-1:0] sel_amt;
  dir_e             sel_dir;
  logic [AMT_W-1:0] sh_amt;
  logic [WIDTH-1:0] rot_data;

  assign free = !out_valid || out_ready;
  // Grants are suppressed in reset so nothing is handed out while the register is held clear.
  assign cand      = (free && rst_n) ? req_valid : '0;
  assign req_ready = gnt;
  assign accept    = |gnt;

  rr_grant #(.NREQ(NREQ)) u_rr_grant (
    .req     (cand),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // One-hot AND-OR mux over the granted requester's payload.
  always_comb begin
    logic dir_bit;
    sel_data = '0;
    sel_amt  = '0;
    dir_bit  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_data = sel_data | ({WIDTH{gnt[i]}} & req_data[i*WIDTH +: WIDTH]);
      sel_amt  = sel_amt  | ({AMT_W{gnt[i]}} & req_amt[i*AMT_W +: AMT_W]);
      dir_bit  = dir_bit  | (gnt[i] & req_dir[i]);
    end
    sel_dir = dir_e'(dir_bit);
  end

  // Right rotate by n is left rotate by (WIDTH - n) mod WIDTH; truncation makes n=0 map to 0.
  assign sh_amt = (sel_dir == ROT_R) ? AMT_W'(WIDTH - int'(sel_amt)) : sel_amt;

  barrel_shift_left #(.WIDTH(WIDTH)) u_shift (
    .data (sel_data),
    .amt  (sh_amt),
    .rot  (rot_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= rot_data;
      out_id    <= gnt_idx;
      rr_ptr    <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_barrel_rot_arbiter.sv
// Directed self-checking bench for barrel_rot_arbiter (WIDTH=8, NREQ=4).
module tb_barrel_rot_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_data;
  logic [N*AW-1:0] req_amt;
  logic [N-1:0]    req_dir;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [IW-1:0]   out_id;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  barrel_rot_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] d,
                         input logic [AW-1:0] a, input logic dir);
    req_valid[i]          = v;
    req_data[i*W +: W]    = d;
    req_amt[i*AW +: AW]   = a;
    req_dir[i]            = dir;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_amt   = '0;
    req_dir   = '0;
    out_ready = 1'b1;

    // Reset: ready must stay low even with a request pending.
    step();
    set_req(0, 1'b1, 8'hAA, 3'd0, 1'b0);
    #1;
    check("ready_in_reset", req_ready, 4'b0000);
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_req_ready", req_ready, 4'b0000);

    // Requester 2: 0x81 rotl 1 -> 0x03. rr_ptr becomes 3.
    step();
    set_req(2, 1'b1, 8'h81, 3'd1, 1'b0);
    #1;
    check("r2_ready", req_ready, 4'b0100);
    step();
    set_req(2, 1'b0, 8'h00, 3'd0, 1'b0);
    check("r2_valid", out_valid, 1);
    check("r2_data", out_data, 8'h03);
    check("r2_id", out_id, 2);

    // Requester 0: 0x81 rotr 1 -> 0xC0; search from 3 wraps to 0. rr_ptr becomes 1.
    set_req(0, 1'b1, 8'h81, 3'd1, 1'b1);
    #1;
    check("r0_ror1_ready", req_ready, 4'b0001);
    step();
    check("r0_ror1_data", out_data, 8'hC0);
    check("r0_ror1_id", out_id, 0);

    // Right by 0 leaves the word unchanged.
    set_req(0, 1'b1, 8'h81, 3'd0, 1'b1);
    step();
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    check("r0_ror0_data", out_data, 8'h81);
    check("r0_ror0_valid", out_valid, 1);

    // Drain with no new job: valid drops, data and id hold.
    step();
    check("drain_valid", out_valid, 0);
    check("drain_data_hold", out_data, 8'h81);
    check("drain_id_hold", out_id, 0);

    // Max left amount: 0x01 rotl 7 -> 0x80 on requester 1 (ptr 1). rr_ptr becomes 2.
    set_req(1, 1'b1, 8'h01, 3'd7, 1'b0);
    step();
    set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    check("r1_rol7_data", out_data, 8'h80);
    check("r1_rol7_id", out_id, 1);

    // 0x0F rotr 3 -> 0xE1 on requester 3. rr_ptr becomes 0.
    set_req(3, 1'b1, 8'h0F, 3'd3, 1'b1);
    step();
    set_req(3, 1'b0, 8'h00, 3'd0, 1'b0);
    check("r3_ror3_data", out_data, 8'hE1);
    check("r3_ror3_id", out_id, 3);

    // Fairness: all valid, data tags the requester; grants 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h10 * (i + 1)), 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("fair_ready_%0d", k), req_ready, 4'b0001 << order[k]);
      step();
      check($sformatf("fair_id_%0d", k), out_id, order[k]);
      check($sformatf("fair_valid_%0d", k), out_valid, 1);
      check($sformatf("fair_data_%0d", k), out_data, 8'h10 * (order[k] + 1));
    end

    // Backpressure: result from requester 0 held; no grants for 5 cycles.
    out_ready = 1'b0;
    #1;
    check("bp_ready_zero", req_ready, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_data_%0d", k), out_data, 8'h10);
      check($sformatf("bp_id_%0d", k), out_id, 0);
      check($sformatf("bp_ready_%0d", k), req_ready, 4'b0000);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 4'b0010);
    step();
    check("bp_release_id", out_id, 1);
    check("bp_release_data", out_data, 8'h20);
    check("bp_release_valid", out_valid, 1);

    // Mid-operation reset with a held result and pending requests.
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_async", out_valid, 0);
    check("midrst_data", out_data, 0);
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(2, 1'b0, 8'h00, 3'd0, 1'b0);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_ready", req_ready, 4'b0010);
    step();
    check("postrst_id", out_id, 1);
    check("postrst_data", out_data, 8'h20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
